// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared register-field, hazard FSM and counter types for the MIPS core
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  localparam int HZ_CNT_W = 3;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_LU    = 2'd1,
    HZ_WAIT  = 2'd2,
    HZ_FLUSH = 2'd3
  } hz_state_t;

  // $0 is hard-wired, so a write to it never produces a forwardable value
  function automatic logic fwd_hit(input logic used, input regbits_t src,
                                   input logic wr, input regbits_t dst);
    return used && (src != 5'd0) && wr && (dst == src);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - lowest-index forwarding source match for one EX operand
module fwd_select
  import cpu_types_pkg::*;
#(
  parameter int NFWD = 2,
  localparam int FW = $clog2(NFWD + 1)
) (
  input  regbits_t              i_src,
  input  logic                  i_used,
  input  logic [NFWD*5-1:0]     i_wsel,
  input  logic [NFWD-1:0]       i_regwrite,
  output logic [FW-1:0]         o_sel
);

  // Scan farthest to nearest so the nearest matching source is written last
  always_comb begin
    o_sel = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_hit(i_used, i_src, i_regwrite[k], i_wsel[k*5 +: 5])) begin
        o_sel = FW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding select plus load-use/dcache-miss/branch stall FSM
// Optional HAZARD_STATS_EN adds saturating lu_stalls/br_flushes/dwait_cycles counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 1,
  parameter int CPUID  = 0,
  parameter int NFWD   = 2,
  parameter int LU_CYC = 1,
  parameter int BR_LAT = 0,
  localparam int FW = $clog2(NFWD + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  regbits_t          ex_rs,
  input  regbits_t          ex_rt,
  input  logic              ex_rs_used,
  input  logic              ex_rt_used,
  input  logic [NFWD*5-1:0] fwd_wsel,
  input  logic [NFWD-1:0]   fwd_regwrite,
  input  regbits_t          id_rs,
  input  regbits_t          id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  regbits_t          ex_wsel,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              dmem_req,
  input  logic              dhit,
  input  logic              ihit,
  input  logic              branch_taken,
  output logic [FW-1:0]     forwardA,
  output logic [FW-1:0]     forwardB,
  output logic              pipe_en,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic              flush_ex,
  output hz_state_t         hz_state
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       lu_stalls,
  output logic [31:0]       br_flushes,
  output logic [31:0]       dwait_cycles
`endif
);

  localparam logic [HZ_CNT_W-1:0] LU_LOAD = HZ_CNT_W'((LU_CYC > 1) ? LU_CYC - 2 : 0);
  localparam logic [HZ_CNT_W-1:0] BR_LOAD = HZ_CNT_W'((BR_LAT > 0) ? BR_LAT - 1 : 0);

  if (CPUID >= CPUS) begin : g_bad_cpuid
  end

  hz_state_t             r_state, w_next_state;
  logic [HZ_CNT_W-1:0]   r_cnt, w_next_cnt;
  logic [FW-1:0]         w_fwd_a, w_fwd_b;
  logic                  w_miss, w_lu_hz;
  logic                  w_pipe_en, w_stall_if, w_stall_id, w_flush_id, w_bubble_ex, w_flush_ex;

  fwd_select #(.NFWD(NFWD)) u_fwd_a (
    .i_src(ex_rs), .i_used(ex_rs_used), .i_wsel(fwd_wsel),
    .i_regwrite(fwd_regwrite), .o_sel(w_fwd_a)
  );

  fwd_select #(.NFWD(NFWD)) u_fwd_b (
    .i_src(ex_rt), .i_used(ex_rt_used), .i_wsel(fwd_wsel),
    .i_regwrite(fwd_regwrite), .o_sel(w_fwd_b)
  );

  assign w_miss  = dmem_req && !dhit;
  assign w_lu_hz = ex_memread && ex_regwrite && (ex_wsel != 5'd0) &&
                   ((id_rs_used && (id_rs == ex_wsel)) || (id_rt_used && (id_rt == ex_wsel)));

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state <= HZ_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      HZ_RUN: begin
        if (w_miss) begin
          w_next_state = HZ_WAIT;
        end else if (branch_taken) begin
          if (BR_LAT > 0) begin
            w_next_state = HZ_FLUSH;
            w_next_cnt   = BR_LOAD;
          end
        end else if (w_lu_hz) begin
          if (LU_CYC > 1) begin
            w_next_state = HZ_LU;
            w_next_cnt   = LU_LOAD;
          end
        end
      end
      HZ_LU: begin
        if (w_miss) begin
          w_next_state = HZ_WAIT;
          w_next_cnt   = '0;
        end else if (r_cnt == '0) begin
          w_next_state = HZ_RUN;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      HZ_WAIT: begin
        if (dhit) w_next_state = HZ_RUN;
      end
      HZ_FLUSH: begin
        if (r_cnt == '0) w_next_state = HZ_RUN;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      default: w_next_state = HZ_RUN;
    endcase
  end

  always_comb begin
    w_pipe_en   = 1'b1;
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_flush_id  = 1'b0;
    w_bubble_ex = 1'b0;
    w_flush_ex  = 1'b0;
    case (r_state)
      HZ_RUN: begin
        if (w_miss) begin
          w_pipe_en = 1'b0;
        end else if (branch_taken) begin
          w_flush_id  = 1'b1;
          w_bubble_ex = 1'b1;
          w_flush_ex  = 1'b1;
        end else if (w_lu_hz) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_bubble_ex = 1'b1;
        end else if (!ihit) begin
          w_stall_if = 1'b1;
          w_flush_id = 1'b1;
        end
      end
      HZ_LU: begin
        w_stall_if  = 1'b1;
        w_stall_id  = 1'b1;
        w_bubble_ex = 1'b1;
      end
      HZ_WAIT:  w_pipe_en  = dhit;
      HZ_FLUSH: w_flush_id = 1'b1;
      default:  w_pipe_en  = 1'b1;
    endcase
  end

  // Reset forces every control low combinationally, so an abort takes effect without waiting for a clock
  assign pipe_en   = w_pipe_en   && !nRST;
  assign stall_if  = w_stall_if  && !nRST;
  assign stall_id  = w_stall_id  && !nRST;
  assign flush_id  = w_flush_id  && !nRST;
  assign bubble_ex = w_bubble_ex && !nRST;
  assign flush_ex  = w_flush_ex  && !nRST;
  assign forwardA  = nRST ? '0 : w_fwd_a;
  assign forwardB  = nRST ? '0 : w_fwd_b;
  assign hz_state  = r_state;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_lu_stalls, r_br_flushes, r_dwait_cycles;

  // A bubble without flush_ex can only come from a load-use stall; flush_ex marks a taken branch
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_lu_stalls    <= '0;
      r_br_flushes   <= '0;
      r_dwait_cycles <= '0;
    end else begin
      if (bubble_ex && !flush_ex && (r_lu_stalls != '1)) r_lu_stalls <= r_lu_stalls + 1'b1;
      if (flush_ex && (r_br_flushes != '1))              r_br_flushes <= r_br_flushes + 1'b1;
      if (!pipe_en && (r_dwait_cycles != '1))            r_dwait_cycles <= r_dwait_cycles + 1'b1;
    end
  end

  assign lu_stalls    = r_lu_stalls;
  assign br_flushes   = r_br_flushes;
  assign dwait_cycles = r_dwait_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (NFWD=2, LU_CYC=3, BR_LAT=2)
module tb_hazard_ctrl;

  localparam int NFWD   = 2;
  localparam int LU_CYC = 3;
  localparam int BR_LAT = 2;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [4:0] ex_rs, ex_rt, id_rs, id_rt, ex_wsel;
  logic       ex_rs_used, ex_rt_used, id_rs_used, id_rt_used;
  logic [9:0] fwd_wsel;
  logic [1:0] fwd_regwrite;
  logic       ex_regwrite, ex_memread, dmem_req, dhit, ihit, branch_taken;
  logic [1:0] forwardA, forwardB, hz_state;
  logic       pipe_en, stall_if, stall_id, flush_id, bubble_ex, flush_ex;
`ifdef HAZARD_STATS_EN
  logic [31:0] lu_stalls, br_flushes, dwait_cycles;
`endif

  hazard_ctrl #(.CPUS(1), .CPUID(0), .NFWD(NFWD), .LU_CYC(LU_CYC), .BR_LAT(BR_LAT)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_used(ex_rs_used), .ex_rt_used(ex_rt_used),
    .fwd_wsel(fwd_wsel), .fwd_regwrite(fwd_regwrite),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_wsel(ex_wsel), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .dmem_req(dmem_req), .dhit(dhit), .ihit(ihit), .branch_taken(branch_taken),
    .forwardA(forwardA), .forwardB(forwardB), .pipe_en(pipe_en),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .flush_ex(flush_ex), .hz_state(hz_state)
`ifdef HAZARD_STATS_EN
    , .lu_stalls(lu_stalls), .br_flushes(br_flushes), .dwait_cycles(dwait_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {pipe_en, stall_if, stall_id, flush_id, bubble_ex, flush_ex, hz_state[1:0]}
  function automatic logic [7:0] dut_ctl();
    return {pipe_en, stall_if, stall_id, flush_id, bubble_ex, flush_ex, hz_state};
  endfunction

  task automatic quiet();
    ex_rs = 0; ex_rt = 0; ex_rs_used = 0; ex_rt_used = 0;
    fwd_wsel = 0; fwd_regwrite = 0;
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    ex_wsel = 0; ex_regwrite = 0; ex_memread = 0;
    dmem_req = 0; dhit = 1; ihit = 1; branch_taken = 0;
  endtask

  // Reference model: remaining cycles of each pending condition instead of an encoded state
  bit m_wait;
  int m_lu_left, m_fl_left;
  int m_lu_st, m_br, m_dw;

  function automatic int model_fwd(input logic [4:0] src, input logic used);
    for (int k = 0; k < NFWD; k++)
      if (used && src != 0 && fwd_regwrite[k] && fwd_wsel[k*5 +: 5] == src) return k + 1;
    return 0;
  endfunction

  function automatic bit model_lu();
    return ex_memread && ex_regwrite && ex_wsel != 0 &&
           ((id_rs_used && id_rs == ex_wsel) || (id_rt_used && id_rt == ex_wsel));
  endfunction

  function automatic logic [7:0] model_ctl();
    bit pe, sif, sid, fid, bex, fex;
    int hz;
    bit miss;
    miss = dmem_req && !dhit;
    pe = 1; sif = 0; sid = 0; fid = 0; bex = 0; fex = 0; hz = 0;
    if (m_wait) begin
      hz = 2; pe = dhit;
    end else if (m_lu_left > 0) begin
      hz = 1; sif = 1; sid = 1; bex = 1;
    end else if (m_fl_left > 0) begin
      hz = 3; fid = 1;
    end else if (miss) pe = 0;
    else if (branch_taken) begin fid = 1; bex = 1; fex = 1; end
    else if (model_lu()) begin sif = 1; sid = 1; bex = 1; end
    else if (!ihit) begin sif = 1; fid = 1; end
    return {pe, sif, sid, fid, bex, fex, 2'(hz)};
  endfunction

  task automatic model_step();
    bit miss;
    miss = dmem_req && !dhit;
    if (m_wait) begin
      if (dhit) m_wait = 0; else m_dw++;
    end else if (m_lu_left > 0) begin
      m_lu_st++;
      if (miss) begin m_lu_left = 0; m_wait = 1; end
      else m_lu_left--;
    end else if (m_fl_left > 0) m_fl_left--;
    else if (miss) begin m_dw++; m_wait = 1; end
    else if (branch_taken) begin m_br++; m_fl_left = BR_LAT; end
    else if (model_lu()) begin m_lu_st++; m_lu_left = LU_CYC - 1; end
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       rs_used, rt_used;
    logic [9:0] wsel;
    logic [1:0] rw;
    logic [1:0] ea, eb;
  } fv_t;

  typedef struct {
    logic       req, hit, br;
    logic [7:0] exp;
  } sv_t;

  fv_t fv[6];
  sv_t ws[9];
  logic [7:0] lu_exp[4];

  initial begin
    fv[0] = '{rs: 5, rt: 0, rs_used: 1, rt_used: 1, wsel: {5'd5, 5'd5}, rw: 2'b11, ea: 1, eb: 0};
    fv[1] = '{rs: 5, rt: 0, rs_used: 1, rt_used: 1, wsel: {5'd5, 5'd5}, rw: 2'b10, ea: 2, eb: 0};
    fv[2] = '{rs: 0, rt: 0, rs_used: 1, rt_used: 1, wsel: {5'd0, 5'd0}, rw: 2'b11, ea: 0, eb: 0};
    fv[3] = '{rs: 7, rt: 7, rs_used: 0, rt_used: 1, wsel: {5'd2, 5'd7}, rw: 2'b01, ea: 0, eb: 1};
    fv[4] = '{rs: 3, rt: 9, rs_used: 1, rt_used: 1, wsel: {5'd3, 5'd9}, rw: 2'b11, ea: 2, eb: 1};
    fv[5] = '{rs: 3, rt: 9, rs_used: 1, rt_used: 1, wsel: {5'd3, 5'd9}, rw: 2'b00, ea: 0, eb: 0};

    lu_exp[0] = 8'b1110_1000; lu_exp[1] = 8'b1110_1001;
    lu_exp[2] = 8'b1110_1001; lu_exp[3] = 8'b1000_0000;

    ws[0] = '{1, 0, 1, 8'b0000_0000};
    ws[1] = '{1, 0, 1, 8'b0000_0010};
    ws[2] = '{1, 0, 1, 8'b0000_0010};
    ws[3] = '{1, 0, 1, 8'b0000_0010};
    ws[4] = '{1, 1, 1, 8'b1000_0010};
    ws[5] = '{0, 1, 1, 8'b1001_1100};
    ws[6] = '{0, 1, 0, 8'b1001_0011};
    ws[7] = '{0, 1, 0, 8'b1001_0011};
    ws[8] = '{0, 1, 0, 8'b1000_0000};

    // Reset state with a forwarding match present on the inputs
    quiet();
    nRST = 1;
    ex_rs = 5; ex_rs_used = 1; fwd_wsel = {5'd5, 5'd5}; fwd_regwrite = 2'b11;
    @(negedge CLK);
    chk("reset_ctl", 32'(dut_ctl()), 32'h0);
    chk("reset_fwdA", 32'(forwardA), 32'h0);
    @(negedge CLK);
    nRST = 0;
    quiet();
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) begin
      ex_rs = fv[i].rs; ex_rt = fv[i].rt;
      ex_rs_used = fv[i].rs_used; ex_rt_used = fv[i].rt_used;
      fwd_wsel = fv[i].wsel; fwd_regwrite = fv[i].rw;
      @(negedge CLK);
      chk($sformatf("fwd%0d_A", i), 32'(forwardA), 32'(fv[i].ea));
      chk($sformatf("fwd%0d_B", i), 32'(forwardB), 32'(fv[i].eb));
      chk($sformatf("fwd%0d_ctl", i), 32'(dut_ctl()), 32'h80);
      @(posedge CLK); #1;
    end
    quiet();

    // Load-use: load info is bubbled out of EX after the first stall cycle
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        ex_memread = 1; ex_regwrite = 1; ex_wsel = 8; id_rt = 8; id_rt_used = 1;
      end else quiet();
      @(negedge CLK);
      chk($sformatf("lu_c%0d", c), 32'(dut_ctl()), 32'(lu_exp[c]));
      @(posedge CLK); #1;
    end

    // Data miss with a branch held in MEM, then the branch squash
    for (int c = 0; c < 9; c++) begin
      dmem_req = ws[c].req; dhit = ws[c].hit; branch_taken = ws[c].br;
      @(negedge CLK);
      chk($sformatf("wait_br_c%0d", c), 32'(dut_ctl()), 32'(ws[c].exp));
      @(posedge CLK); #1;
    end
    quiet();
`ifdef HAZARD_STATS_EN
    chk("stats_lu", lu_stalls, 32'd3);
    chk("stats_dwait", dwait_cycles, 32'd4);
    chk("stats_br", br_flushes, 32'd1);
`endif

    // Reset in the middle of a load-use stall
    ex_memread = 1; ex_regwrite = 1; ex_wsel = 8; id_rs = 8; id_rs_used = 1;
    @(posedge CLK); #1;
    quiet();
    ex_rs = 4; ex_rs_used = 1; fwd_wsel = {5'd0, 5'd4}; fwd_regwrite = 2'b01;
    @(negedge CLK);
    chk("midlu_before", 32'(dut_ctl()), 32'b1110_1001);
    #2 nRST = 1;
    #1;
    chk("midlu_rst_ctl", 32'(dut_ctl()), 32'h0);
    chk("midlu_rst_fwdA", 32'(forwardA), 32'h0);
    @(negedge CLK);
    chk("midlu_rst_hold", 32'(dut_ctl()), 32'h0);
    nRST = 0;
    quiet();
    @(negedge CLK);
    chk("midlu_release", 32'(dut_ctl()), 32'h80);
    m_wait = 0; m_lu_left = 0; m_fl_left = 0; m_lu_st = 0; m_br = 0; m_dw = 0;
    @(posedge CLK); #1;

    // Randomized run against the reference model
    for (int c = 0; c < 600; c++) begin
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rs_used = 1'($urandom_range(0, 1)); ex_rt_used = 1'($urandom_range(0, 1));
      fwd_wsel = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_regwrite = 2'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rs_used = 1'($urandom_range(0, 1)); id_rt_used = 1'($urandom_range(0, 1));
      ex_wsel = 5'($urandom_range(0, 3));
      ex_regwrite = ($urandom_range(0, 3) != 0);
      ex_memread = ($urandom_range(0, 2) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dhit = ($urandom_range(0, 4) < 3);
      ihit = ($urandom_range(0, 4) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      @(negedge CLK);
      chk($sformatf("rand%0d_ctl", c), 32'(dut_ctl()), 32'(model_ctl()));
      chk($sformatf("rand%0d_fwd", c), 32'({forwardA, forwardB}),
          32'({2'(model_fwd(ex_rs, ex_rs_used)), 2'(model_fwd(ex_rt, ex_rt_used))}));
      @(posedge CLK);
      model_step();
      #1;
    end
`ifdef HAZARD_STATS_EN
    chk("rand_stats_lu", lu_stalls, 32'(m_lu_st));
    chk("rand_stats_br", br_flushes, 32'(m_br));
    chk("rand_stats_dwait", dwait_cycles, 32'(m_dw));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
